// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream into the program loader and its byte write port toward the instruction RAM.
// The master modport is the loader side; the slave modport is the byte source / RAM side.
interface imem_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;

  modport master (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: accepts a little-endian 16-bit length header plus program image and writes it byte-wise from BASE_ADDR.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte that decides DONE vs ERR.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_rst,
  output logic          busy,
  output logic          done,
  output logic          error
);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;
  localparam state_t S_PAYLOAD_END = S_CSUM;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_DONE, S_ERR
  } state_t;
  localparam state_t S_PAYLOAD_END = S_DONE;
`endif

  state_t      state_q, state_d;
  logic        in_ready;
  logic        accept;
  logic        restart;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [15:0] len_new;
  logic        len_too_big;
  logic        last_byte;
  logic        we_p1;
  logic [31:0] addr_p1;
  logic [7:0]  wdata_p1;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  assign accept      = bus.in_valid && in_ready;
  assign restart     = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERR);
  assign len_new     = {bus.in_data, len_q[7:0]};
  assign len_too_big = {16'd0, len_new} > 32'(MEM_BYTES);
  assign last_byte   = (cnt_q == len_q - 16'd1);

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = we_p1;
  assign bus.mem_addr  = addr_p1;
  assign bus.mem_wdata = wdata_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    core_rst = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        core_rst = 1'b1;
        if (accept) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        core_rst = 1'b1;
        if (accept) begin
          if (len_too_big)          state_d = S_ERR;
          else if (len_new == 16'd0) state_d = S_PAYLOAD_END;
          else                       state_d = S_DATA;
        end
      end
      S_DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        core_rst = 1'b1;
        if (accept && last_byte) state_d = S_PAYLOAD_END;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        core_rst = 1'b1;
        if (accept) state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
      end
`endif
      S_DONE: begin
        done = 1'b1;
        if (start) state_d = S_LEN_LO;
      end
      S_ERR: begin
        error    = 1'b1;
        core_rst = 1'b1;
        if (start) state_d = S_LEN_LO;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Write stage: the accepting edge registers the RAM write, so mem_we lags the accept by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= 16'd0;
      cnt_q    <= 16'd0;
      we_p1    <= 1'b0;
      addr_p1  <= 32'd0;
      wdata_p1 <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q   <= 8'd0;
`endif
    end else begin
      we_p1 <= 1'b0;
      if (accept) begin
        case (state_q)
          S_LEN_LO: len_q[7:0] <= bus.in_data;
          S_LEN_HI: begin
            len_q[15:8] <= bus.in_data;
            cnt_q       <= 16'd0;
          end
          S_DATA: begin
            cnt_q    <= cnt_q + 16'd1;
            we_p1    <= 1'b1;
            addr_p1  <= BASE_ADDR + {16'd0, cnt_q};
            wdata_p1 <= bus.in_data;
          end
          default: ;
        endcase
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (restart)                          csum_q <= 8'd0;
      else if (accept && state_q == S_DATA) csum_q <= csum_q ^ bus.in_data;
`endif
    end
  end

  logic unused_restart;
  assign unused_restart = restart;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed test-plan loads plus randomized loads, checked every cycle against a byte-count model.
// Honours IMEM_LOADER_CHECKSUM_EN to build streams with or without the trailing checksum byte.
`timescale 1ns/1ps
module tb_imem_loader;
  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MEMB = 1024;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic core_rst, busy, done, error;
  imem_loader_if bus();

  imem_loader #(.BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.master),
    .core_rst(core_rst), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a load is "the next N bytes after start", N derived from the header.
  logic        m_loading = 1'b0, m_done = 1'b0, m_err = 1'b0, m_we = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [7:0]  m_wdata = 8'd0, m_xor = 8'd0;
  logic [15:0] m_len = 16'd0;
  int          m_cnt = 0;

  task automatic m_finish(input bit ok);
    m_loading = 1'b0;
    m_done    = ok;
    m_err     = !ok;
  endtask

  task automatic m_byte(input logic [7:0] b);
    int k;
    if (m_cnt == 0) m_len[7:0] = b;
    else if (m_cnt == 1) begin
      m_len[15:8] = b;
      if (int'(m_len) > MEMB) m_finish(1'b0);
      else if (m_len == 16'd0 && !CSUM) m_finish(1'b1);
    end else begin
      k = m_cnt - 2;
      if (k < int'(m_len)) begin
        m_we    = 1'b1;
        m_addr  = BASE + 32'(k);
        m_wdata = b;
        m_xor   = m_xor ^ b;
        if (k == int'(m_len) - 1 && !CSUM) m_finish(1'b1);
      end else m_finish(b == m_xor);
    end
    m_cnt++;
  endtask

  initial forever begin
    @(posedge clk);
    m_we = 1'b0;
    if (rst) begin
      m_loading = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else if (m_loading) begin
      if (bus.in_valid) m_byte(bus.in_data);
    end else if (start) begin
      m_loading = 1'b1; m_done = 1'b0; m_err = 1'b0; m_cnt = 0; m_xor = 8'd0;
    end
  end

  // Per-cycle compare plus a shadow RAM of everything the DUT wrote
  logic [7:0]  ram [0:MEMB-1];
  int          wr_cnt = 0;
  logic [31:0] last_addr = 32'd0;

  initial forever begin
    @(negedge clk);
    chk("in_ready", bus.in_ready, m_loading);
    chk("busy", busy, m_loading);
    chk("core_rst", core_rst, m_loading || m_err);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("mem_we", bus.mem_we, m_we);
    if (m_we) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, m_wdata);
    end
    if (bus.mem_we === 1'b1) begin
      ram[bus.mem_addr % MEMB] = bus.mem_wdata;
      last_addr = bus.mem_addr;
      wr_cnt++;
    end
  end

  logic [7:0] stream [$];

  task automatic build(input int len, input bit good_csum);
    logic [7:0] x, b;
    x = 8'd0;
    stream.delete();
    stream.push_back(len[7:0]);
    stream.push_back(len[15:8]);
    if (len <= MEMB) begin
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        stream.push_back(b);
        x = x ^ b;
      end
      if (CSUM) stream.push_back(good_csum ? x : ~x);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: valid held, 1: alternating 1,0,1,..., 2: random gaps with random stray starts
  task automatic send(input int mode, input int nmax);
    int  i, cyc;
    bit  tog, v, rdy;
    i = 0; cyc = 0; tog = 1'b1;
    while (i < stream.size() && i < nmax) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = tog;
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      tog = !tog;
      bus.in_data  = stream[i];
      bus.in_valid = v;
      start        = (mode == 2) && ($urandom_range(0, 7) == 0);
      rdy          = bus.in_ready;
      @(posedge clk); #1;
      if (v && rdy) i++;
      cyc++;
      if (cyc > 5000) begin
        checks++; errors++;
        $display("FAIL send_timeout: consumed %0d of %0d bytes", i, stream.size());
        break;
      end
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  initial begin
    int w0;
    bus.in_data = 8'd0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 8'd0);
    chk("rst_core_rst", core_rst, 1'b0);

    // Four-byte instruction image
    stream = '{8'h04, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
    if (CSUM) stream.push_back(8'h06);
    w0 = wr_cnt;
    do_start();
    send(0, 100);
`ifndef IMEM_LOADER_CHECKSUM_EN
    chk("last_we_with_done", {bus.mem_we, done, core_rst, bus.mem_addr[7:0]}, {1'b1, 1'b1, 1'b0, 8'h03});
`endif
    @(negedge clk);
    chk("t1_done", {done, core_rst}, 2'b10);
    chk("t1_writes", wr_cnt - w0, 4);
    chk("t1_word", {ram[3], ram[2], ram[1], ram[0]}, 32'h0010_0513);

    // Oversized length is rejected after the header
    stream = '{8'h01, 8'h04};
    w0 = wr_cnt;
    do_start();
    send(0, 2);
    @(negedge clk);
    chk("t2_error", {error, core_rst, busy}, 3'b110);
    chk("t2_no_writes", wr_cnt, w0);
    do_start();
    chk("t2_error_cleared", {error, busy}, 2'b01);
    stream = '{8'h00, 8'h00};
    if (CSUM) stream.push_back(8'h00);
    send(0, 10);
    @(negedge clk);
    chk("t7_len0_done", done, 1'b1);
    chk("t7_len0_no_writes", wr_cnt, w0);

    // Three-byte payload with in_valid toggling
    stream = '{8'h03, 8'h00, 8'hA1, 8'hB2, 8'hC3};
    if (CSUM) stream.push_back(8'hA1 ^ 8'hB2 ^ 8'hC3);
    w0 = wr_cnt;
    do_start();
    send(1, 100);
    @(negedge clk);
    chk("t3_writes", wr_cnt - w0, 3);
    chk("t3_bytes", {ram[2], ram[1], ram[0]}, 24'hC3B2A1);

    // Reset in the middle of a load
    build(8, 1'b1);
    w0 = wr_cnt;
    do_start();
    send(0, 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_after_rst", {bus.mem_we, busy, core_rst, bus.in_ready}, 4'b0000);
    bus.in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 bus.in_valid = 1'b0;
    chk("t4_writes", wr_cnt - w0, 2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    stream = '{8'h02, 8'h00, 8'hAA, 8'h55, 8'hFF};
    do_start();
    send(0, 10);
    @(negedge clk);
    chk("t5_csum_good", {done, error}, 2'b10);
    stream = '{8'h02, 8'h00, 8'hAA, 8'h55, 8'hFE};
    do_start();
    send(0, 10);
    @(negedge clk);
    chk("t5_csum_bad", {done, error, core_rst}, 3'b011);
`endif

    // Full-capacity image
    build(MEMB, 1'b1);
    w0 = wr_cnt;
    do_start();
    send(0, MEMB + 4);
    @(negedge clk);
    chk("t6_full_done", done, 1'b1);
    chk("t6_full_writes", wr_cnt - w0, MEMB);
    chk("t6_last_addr", last_addr, BASE + 32'(MEMB - 1));

    // Randomized loads with gaps, stray starts and idle valid bytes in between
    for (int n = 0; n < 40; n++) begin
      int len;
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(MEMB + 1, 65535) : $urandom_range(0, 20);
      build(len, $urandom_range(0, 3) != 0);
      do_start();
      send($urandom_range(0, 2), stream.size());
      bus.in_valid = 1'b1;
      bus.in_data = 8'($urandom_range(0, 255));
      repeat ($urandom_range(1, 4)) @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
